brownout_cmp_array: RTL and testbench

Parametrised, clocked, multi-channel successor to the single-channel comparator model. Each channel compares two digitised codes, vinp and vinn, with programmable hysteresis and a debounce filter. Outputs are gated by a shared enable and a bias-good qualifier. Per-channel sticky trip flags and change pulses go to the brownout controller, which consumes them.

---
 rtl/brownout_cmp_array.sv | 101 ++++++++++
 tb/tb_brownout_cmp_array.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brownout_cmp_array.sv
// Multi-channel clocked comparator array with hysteresis, debounce filter,
// enable/bias gating, sticky rising-trip flags and per-channel change pulses.
module brownout_cmp_array #(
   parameter int NCH = 4,
   parameter int W   = 8,
   parameter int HW  = 4,
   parameter int DBW = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ena,
   input  logic             ibias_ok,
   input  logic [NCH*W-1:0] vinp,
   input  logic [NCH*W-1:0] vinn,
   input  logic [HW-1:0]    hyst,
   input  logic [DBW-1:0]   dbnc_len,
   input  logic [NCH-1:0]   clr_sticky,
   output logic [NCH-1:0]   dout,
   output logic [NCH-1:0]   sticky,
   output logic [NCH-1:0]   chg,
   output logic             any_out
);

   logic [NCH-1:0] dout_q, dout_d;
   logic [NCH-1:0] sticky_q, sticky_d;
   logic [NCH-1:0] chg_q, chg_d;
   logic [DBW-1:0] cnt_q [NCH];
   logic [DBW-1:0] cnt_d [NCH];

   logic           active_s;
   logic [W:0]     p_s;
   logic [W:0]     n_s;
   logic [W:0]     nh_s;
   logic           cand_s;

   assign active_s = ena & ibias_ok;

   // Per-channel candidate, debounce counter and next-state for all flags.
   always_comb begin
      dout_d   = dout_q;
      sticky_d = sticky_q;
      chg_d    = {NCH{1'b0}};
      p_s      = {(W+1){1'b0}};
      n_s      = {(W+1){1'b0}};
      nh_s     = {(W+1){1'b0}};
      cand_s   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         // One extra bit so vinn + hyst cannot wrap past the top code.
         p_s  = {1'b0, vinp[i*W +: W]};
         n_s  = {1'b0, vinn[i*W +: W]};
         nh_s = n_s + {{(W+1-HW){1'b0}}, hyst};
         if (dout_q[i]) begin
            cand_s = (p_s > n_s);
         end else begin
            cand_s = (p_s > nh_s);
         end

         if (!active_s) begin
            dout_d[i] = 1'b0;
            cnt_d[i]  = {DBW{1'b0}};
         end else if (cand_s == dout_q[i]) begin
            cnt_d[i]  = {DBW{1'b0}};
         end else if (cnt_q[i] == dbnc_len) begin
            dout_d[i] = ~dout_q[i];
            cnt_d[i]  = {DBW{1'b0}};
         end else begin
            cnt_d[i]  = cnt_q[i] + DBW'(1);
         end

         chg_d[i]    = dout_d[i] ^ dout_q[i];
         // A rising trip on the same edge as a clear keeps the flag set.
         sticky_d[i] = (dout_d[i] & ~dout_q[i]) | (sticky_q[i] & ~clr_sticky[i]);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout_q   <= {NCH{1'b0}};
         sticky_q <= {NCH{1'b0}};
         chg_q    <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= {DBW{1'b0}};
         end
      end else begin
         dout_q   <= dout_d;
         sticky_q <= sticky_d;
         chg_q    <= chg_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign dout    = dout_q;
   assign sticky  = sticky_q;
   assign chg     = chg_q;
   assign any_out = |dout_q;

endmodule

// File: tb/tb_brownout_cmp_array.sv
// Scoreboard bench for brownout_cmp_array: expectations are queued as stimulus
// is applied and popped when the outputs are sampled on the falling edge.
module tb_brownout_cmp_array;

   logic        clk;
   logic        rstn;
   logic        ena;
   logic        ibias_ok;
   logic [31:0] vinp;
   logic [31:0] vinn;
   logic [3:0]  hyst;
   logic [3:0]  dbnc_len;
   logic [3:0]  clr_sticky;
   logic [3:0]  dout;
   logic [3:0]  sticky;
   logic [3:0]  chg;
   logic        any_out;

   typedef struct {
      string      nm;
      logic [3:0] d;
      logic [3:0] c;
      logic [3:0] s;
      logic       a;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks;
   int   n_fail;

   brownout_cmp_array #(.NCH(4), .W(8), .HW(4), .DBW(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .ena        (ena),
      .ibias_ok   (ibias_ok),
      .vinp       (vinp),
      .vinn       (vinn),
      .hyst       (hyst),
      .dbnc_len   (dbnc_len),
      .clr_sticky (clr_sticky),
      .dout       (dout),
      .sticky     (sticky),
      .chg        (chg),
      .any_out    (any_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(string nm, logic [3:0] d, logic [3:0] c, logic [3:0] s);
      exp_t r;
      r.nm = nm;
      r.d  = d;
      r.c  = c;
      r.s  = s;
      r.a  = |d;
      return r;
   endfunction

   task automatic test_reset;
      #1;
      sb.push_back(mk("reset_init", 4'b0000, 4'b0000, 4'b0000));
      e = sb.pop_front();
      n_checks++;
      if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
         n_fail++;
         $display("FAIL %s: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                  e.nm, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
      end
      @(negedge clk);
      rstn = 1'b1; ena = 1'b1; ibias_ok = 1'b1; hyst = 4'd0; dbnc_len = 4'd0;
      vinp = 32'h1010_1010; vinn = 32'h0000_0000;
      sb.push_back(mk("reset_fill", 4'b1111, 4'b1111, 4'b1111));
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
         n_fail++;
         $display("FAIL %s: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                  e.nm, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
      end
      #2 rstn = 1'b0;
      #1;
      sb.push_back(mk("reset_async", 4'b0000, 4'b0000, 4'b0000));
      e = sb.pop_front();
      n_checks++;
      if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
         n_fail++;
         $display("FAIL %s: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                  e.nm, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
      end
      @(negedge clk);
      rstn = 1'b1; ena = 1'b0;
      for (int k = 0; k < 20; k++) begin
         sb.push_back(mk("idle_disabled", 4'b0000, 4'b0000, 4'b0000));
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
            n_fail++;
            $display("FAIL %s[%0d]: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                     e.nm, k, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
         end
      end
      vinp = 32'h0000_0000;
   endtask

   task automatic test_basic;
      logic [7:0] tp [4] = '{8'h81, 8'h81, 8'h80, 8'h80};
      logic [3:0] td [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
      logic [3:0] tc [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
      ena = 1'b1; ibias_ok = 1'b1; hyst = 4'd0; dbnc_len = 4'd0;
      vinn[7:0] = 8'h80;
      for (int k = 0; k < 4; k++) begin
         vinp[7:0] = tp[k];
         sb.push_back(mk("basic", td[k], tc[k], 4'b0001));
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
            n_fail++;
            $display("FAIL %s[%0d]: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                     e.nm, k, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
         end
      end
   endtask

   task automatic test_hysteresis;
      logic [7:0] tn [9] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'hFF, 8'hFF};
      logic [7:0] tp [9] = '{8'h40, 8'h44, 8'h45, 8'h45, 8'h41, 8'h40, 8'h40, 8'hFF, 8'hFF};
      logic [3:0] th [9] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'hF, 4'hF};
      logic [3:0] td [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000};
      logic [3:0] tc [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                             4'b0000, 4'b0000};
      for (int k = 0; k < 9; k++) begin
         vinn[7:0] = tn[k]; vinp[7:0] = tp[k]; hyst = th[k];
         sb.push_back(mk("hysteresis", td[k], tc[k], 4'b0001));
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
            n_fail++;
            $display("FAIL %s[%0d]: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                     e.nm, k, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
         end
      end
   endtask

   task automatic test_debounce;
      logic [7:0] tp [9] = '{8'h20, 8'h20, 8'h20, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
      logic [3:0] td [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0001, 4'b0001};
      logic [3:0] tc [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0001, 4'b0000};
      hyst = 4'd0; dbnc_len = 4'd3; vinn[7:0] = 8'h10;
      for (int k = 0; k < 9; k++) begin
         vinp[7:0] = tp[k];
         sb.push_back(mk("debounce_l3", td[k], tc[k], 4'b0001));
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
            n_fail++;
            $display("FAIL %s[%0d]: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                     e.nm, k, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
         end
      end
      dbnc_len = 4'd15; vinp[7:0] = 8'h00;
      for (int k = 0; k < 17; k++) begin
         sb.push_back(mk("debounce_l15", (k < 15) ? 4'b0001 : 4'b0000,
                         (k == 15) ? 4'b0001 : 4'b0000, 4'b0001));
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
            n_fail++;
            $display("FAIL %s[%0d]: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                     e.nm, k, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
         end
      end
   endtask

   task automatic test_gating;
      logic       tb_ok [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] tl [7] = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2};
      logic [3:0] td [7] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
      logic [3:0] tc [7] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      vinp[23:16] = 8'h50; vinn[23:16] = 8'h10;
      for (int k = 0; k < 7; k++) begin
         ibias_ok = tb_ok[k]; dbnc_len = tl[k];
         sb.push_back(mk("gating", td[k], tc[k], 4'b0101));
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
            n_fail++;
            $display("FAIL %s[%0d]: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                     e.nm, k, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
         end
      end
   endtask

   task automatic test_sticky_race;
      logic [3:0] tclr [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b1111};
      logic [3:0] tc   [4] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000};
      logic [3:0] ts   [4] = '{4'b0111, 4'b0101, 4'b0101, 4'b0000};
      dbnc_len = 4'd0;
      vinp[15:8] = 8'h30; vinn[15:8] = 8'h20;
      for (int k = 0; k < 4; k++) begin
         clr_sticky = tclr[k];
         sb.push_back(mk("sticky_race", 4'b0110, tc[k], ts[k]));
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if ({dout, chg, sticky, any_out} !== {e.d, e.c, e.s, e.a}) begin
            n_fail++;
            $display("FAIL %s[%0d]: dout/chg/sticky/any got %b/%b/%b/%b exp %b/%b/%b/%b",
                     e.nm, k, dout, chg, sticky, any_out, e.d, e.c, e.s, e.a);
         end
      end
      clr_sticky = 4'b0000;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rstn = 1'b0; ena = 1'b0; ibias_ok = 1'b0;
      vinp = 32'h0000_0000; vinn = 32'h0000_0000;
      hyst = 4'd0; dbnc_len = 4'd0; clr_sticky = 4'b0000;
      test_reset();
      test_basic();
      test_hysteresis();
      test_debounce();
      test_gating();
      test_sticky_race();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
